// File: rtl/score_pkg.sv
// Shared types and constants for the BCD score counter.
package score_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    FINISH
  } add_state_t;

endpackage

// File: rtl/bcd_digit_up.sv
// One BCD digit of the up counter: load, increment on carry-in, wrap 9 -> 0.
module bcd_digit_up
  import score_pkg::*;
(
  input  logic               clk,
  input  logic               resetN,
  input  logic               loadN,
  input  logic [DIGIT_W-1:0] datain,
  input  logic               cin,
  output logic [DIGIT_W-1:0] count,
  output logic               cout
);

  always_ff @(posedge clk) begin
    if (!resetN) begin
      count <= '0;
    end else if (!loadN) begin
      count <= datain;
    end else if (cin) begin
      // Out-of-range loaded values (>9) also fall back to 0 here.
      if (count >= BCD_MAX) count <= '0;
      else                  count <= count + DIGIT_W'(1);
    end
  end

  assign cout = cin & (count == BCD_MAX);

endmodule

// File: rtl/bcd_up_counter.sv
// Multi-digit saturating BCD up counter that applies "add N" requests
// one unit per tick strobe through a valid/ready handshake.
module bcd_up_counter
  import score_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned AMT_W  = 8
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  loadN,
  input  logic [DIGITS*4-1:0]   datain,
  input  logic                  add_valid,
  input  logic [AMT_W-1:0]      add_amount,
  output logic                  add_ready,
  input  logic                  tick,
  output logic [DIGITS*4-1:0]   count,
  output logic                  busy,
  output logic                  done,
  output logic                  sat
);

  add_state_t       state, state_n;
  logic [AMT_W-1:0] remaining;
  logic             count_en;
  logic [DIGITS:0]  carry;
  logic             carry_unused;

  always_comb begin
    sat = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (count[4*i +: 4] != BCD_MAX) sat = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n   = state;
    add_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    count_en  = 1'b0;
    case (state)
      IDLE: begin
        add_ready = 1'b1;
        if (add_valid) state_n = (add_amount != '0) ? COUNT : FINISH;
      end
      COUNT: begin
        busy = 1'b1;
        if (tick) begin
          if (sat) begin
            state_n = FINISH;
          end else begin
            count_en = 1'b1;
            if (remaining == AMT_W'(1)) state_n = FINISH;
          end
        end
      end
      FINISH: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Load aborts any pending request and drops a same-cycle one.
    if (!loadN) begin
      state_n  = IDLE;
      count_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN || !loadN) begin
      remaining <= '0;
    end else if (state == IDLE && add_valid) begin
      remaining <= add_amount;
    end else if (state == COUNT && tick) begin
      remaining <= sat ? '0 : remaining - AMT_W'(1);
    end
  end

  assign carry[0]     = count_en;
  assign carry_unused = carry[DIGITS];

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_up u_digit (
      .clk    (clk),
      .resetN (resetN),
      .loadN  (loadN),
      .datain (datain[4*i +: 4]),
      .cin    (carry[i]),
      .count  (count[4*i +: 4]),
      .cout   (carry[i+1])
    );
  end

endmodule
